// File: rtl/imm_encoder.sv
// Packs a signed immediate into the I/S/B/J fields of an instruction word, with range/alignment checks and error status.
// One-cycle latency through a valid/ready output register; IMM_ENC_SAT_EN selects clamping instead of truncation.
module imm_encoder #(
    parameter int Width  = 32,
    parameter int ADDR_W = 10,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        immsrc,
    input  logic [Width-1:0]  base,
    input  logic [Width-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [Width-1:0]  instr,
    output logic              out_err,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_sticky,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_S = 2'b01;
    localparam logic [1:0] FMT_B = 2'b10;

    logic              valid_q, valid_d;
    logic [Width-1:0]  instr_q, instr_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sticky_q, sticky_d;
    logic [ADDR_W-1:0] eaddr_q, eaddr_d;
    logic [ERR_W-1:0]  cnt_q, cnt_d;

    logic              in_hs, out_hs;
    logic              range_err, mis_err;
    logic [20:0]       imm_eff;

    assign in_ready = !valid_q || out_ready;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = valid_q && out_ready;

    // Range means the bits above the format's sign bit are a pure sign extension.
    always_comb begin
        range_err = 1'b0;
        mis_err   = 1'b0;
        case (immsrc)
            FMT_I, FMT_S: range_err = !((&imm[31:11]) || !(|imm[31:11]));
            FMT_B: begin
                range_err = !((&imm[31:12]) || !(|imm[31:12]));
                mis_err   = imm[0];
            end
            default: begin
                range_err = !((&imm[31:20]) || !(|imm[31:20]));
                mis_err   = imm[0];
            end
        endcase
    end

    always_comb begin
        imm_eff = imm[20:0];
`ifdef IMM_ENC_SAT_EN
        // B/J positive limits are even so the dropped bit 0 loses nothing.
        if (range_err) begin
            case (immsrc)
                FMT_I, FMT_S: imm_eff = imm[31] ? 21'h1F_F800 : 21'h00_07FF;
                FMT_B:        imm_eff = imm[31] ? 21'h1F_F000 : 21'h00_0FFE;
                default:      imm_eff = imm[31] ? 21'h10_0000 : 21'h0F_FFFE;
            endcase
        end
`endif
    end

    always_comb begin
        instr_d = base;
        case (immsrc)
            FMT_I: instr_d[31:20] = imm_eff[11:0];
            FMT_S: begin
                instr_d[31:25] = imm_eff[11:5];
                instr_d[11:7]  = imm_eff[4:0];
            end
            FMT_B: begin
                instr_d[31]    = imm_eff[12];
                instr_d[30:25] = imm_eff[10:5];
                instr_d[11:8]  = imm_eff[4:1];
                instr_d[7]     = imm_eff[11];
            end
            default: begin
                instr_d[31]    = imm_eff[20];
                instr_d[30:21] = imm_eff[10:1];
                instr_d[20]    = imm_eff[11];
                instr_d[19:12] = imm_eff[19:12];
            end
        endcase
        err_d = range_err || mis_err;
    end

    always_comb begin
        valid_d  = valid_q;
        addr_d   = addr_q;
        sticky_d = sticky_q;
        eaddr_d  = eaddr_q;
        cnt_d    = cnt_q;
        if (in_hs) begin
            valid_d = 1'b1;
        end else if (out_hs) begin
            valid_d = 1'b0;
        end
        // Status follows the word leaving, so a word accepted alongside sees the new address.
        if (out_hs) begin
            addr_d = addr_q + ADDR_W'(1);
            if (err_q) begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + ERR_W'(1);
                end
                if (!sticky_q) begin
                    sticky_d = 1'b1;
                    eaddr_d  = addr_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            instr_q  <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            sticky_q <= 1'b0;
            eaddr_q  <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            sticky_q <= sticky_d;
            eaddr_q  <= eaddr_d;
            cnt_q    <= cnt_d;
            if (in_hs) begin
                instr_q <= instr_d;
                err_q   <= err_d;
            end
        end
    end

    assign out_valid  = valid_q;
    assign instr      = instr_q;
    assign out_err    = err_q;
    assign out_addr   = addr_q;
    assign err_sticky = sticky_q;
    assign err_addr   = eaddr_q;
    assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed encodings, backpressure, reset mid-hold, and a random stream through a wrap.
module tb_imm_encoder;

    localparam int AW = 10;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, out_valid, out_ready, out_err, err_sticky;
    logic [1:0]    immsrc;
    logic [31:0]   base, imm, instr;
    logic [AW-1:0] out_addr, err_addr;
    logic [EW-1:0] err_cnt;

    always #5 clk = ~clk;

    imm_encoder #(.Width(32), .ADDR_W(AW), .ERR_W(EW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .immsrc(immsrc), .base(base), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .out_err(out_err), .out_addr(out_addr),
        .err_sticky(err_sticky), .err_addr(err_addr), .err_cnt(err_cnt)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          out_count = 0;
    int          m_cnt = 0;
    logic        m_sticky = 1'b0;
    int          m_eaddr = 0;
    logic [31:0] last_instr;
    logic        last_err;
    int          last_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic int nbits(input logic [1:0] f);
        if (f == 2'd2) return 13;
        if (f == 2'd3) return 21;
        return 12;
    endfunction

    // Which immediate bit lands on instruction bit i; -1 keeps the base bit.
    function automatic int imm_bit(input logic [1:0] f, input int i);
        if (f == 2'd0) return (i >= 20) ? i - 20 : -1;
        if (f == 2'd1) begin
            if (i >= 25) return i - 20;
            if (i >= 7 && i <= 11) return i - 7;
            return -1;
        end
        if (f == 2'd2) begin
            if (i == 31) return 12;
            if (i >= 25) return i - 20;
            if (i >= 8 && i <= 11) return i - 7;
            if (i == 7) return 11;
            return -1;
        end
        if (i == 31) return 20;
        if (i >= 21) return i - 20;
        if (i == 20) return 11;
        if (i >= 12) return i;
        return -1;
    endfunction

    function automatic exp_t model(input logic [1:0] f, input logic [31:0] b, input logic [31:0] im);
        exp_t        e;
        int          v, lim, eff, k;
        logic        rng, mis;
        logic [31:0] effb;
        v   = im;
        lim = 1 << (nbits(f) - 1);
        rng = (v < -lim) || (v > lim - 1);
        mis = f[1] && im[0];
        eff = v;
`ifdef IMM_ENC_SAT_EN
        if (rng) eff = (v < 0) ? -lim : (f[1] ? lim - 2 : lim - 1);
`endif
        effb = eff;
        for (int i = 0; i < 32; i++) begin
            k = imm_bit(f, i);
            e.instr[i] = (k < 0) ? b[i] : effb[k];
        end
        e.err = rng || mis;
        return e;
    endfunction

    function automatic logic [31:0] rand_imm(input logic [1:0] f);
        int lim, v;
        lim = 1 << (nbits(f) - 1);
        case ($urandom_range(0, 3))
            0: v = int'($urandom_range(0, 2 * lim - 1)) - lim;
            1: v = ($urandom_range(0, 1) != 0 ? lim : -lim) + int'($urandom_range(0, 2)) - 1;
            2: v = int'($urandom);
            default: v = int'($urandom_range(0, 200)) - 100;
        endcase
        return v;
    endfunction

    // Drive one cycle, check outputs at the falling edge, and advance the model at the rising edge.
    task automatic cycle(input logic iv, input logic [1:0] f, input logic [31:0] b,
                         input logic [31:0] im, input logic ordy);
        logic exp_vld, exp_rdy;
        exp_t e;
        in_valid = iv; immsrc = f; base = b; imm = im; out_ready = ordy;
        @(negedge clk);
        exp_vld = (q.size() != 0);
        exp_rdy = !exp_vld || ordy;
        check("out_valid", out_valid, exp_vld);
        check("in_ready", in_ready, exp_rdy);
        check("err_sticky", err_sticky, m_sticky);
        check("err_cnt", err_cnt, m_cnt);
        check("err_addr", err_addr, m_eaddr);
        if (exp_vld) begin
            check("instr", instr, q[0].instr);
            check("out_err", out_err, q[0].err);
            check("out_addr", out_addr, out_count % 1024);
            if (ordy) begin
                e = q.pop_front();
                last_instr = instr;
                last_err   = out_err;
                last_addr  = out_addr;
                if (e.err) begin
                    if (m_cnt < 255) m_cnt++;
                    if (!m_sticky) begin
                        m_sticky = 1'b1;
                        m_eaddr  = out_count % 1024;
                    end
                end
                out_count++;
            end
        end
        if (iv && exp_rdy) q.push_back(model(f, b, im));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        out_count = 0; m_cnt = 0; m_sticky = 1'b0; m_eaddr = 0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_instr"}, instr, 0);
        check({tag, "_out_err"}, out_err, 0);
        check({tag, "_out_addr"}, out_addr, 0);
        check({tag, "_err_sticky"}, err_sticky, 0);
        check({tag, "_err_addr"}, err_addr, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    initial begin
        logic [1:0] rf;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        immsrc = 2'd0; base = '0; imm = '0;
        do_reset();
        reset_checks("rst");

        cycle(1'b1, 2'd0, 32'h0000_0093, 32'hFFFF_FFFF, 1'b1);
        cycle(1'b1, 2'd1, 32'h0020_A023, 32'd8, 1'b1);
        check("tp_i_instr", last_instr, 32'hFFF0_0093);
        check("tp_i_err", last_err, 0);
        check("tp_i_addr", last_addr, 0);
        cycle(1'b1, 2'd2, 32'h0000_0063, 32'hFFFF_FFFC, 1'b1);
        check("tp_s_instr", last_instr, 32'h0020_A423);
        check("tp_s_addr", last_addr, 1);
        cycle(1'b1, 2'd3, 32'h0000_00EF, 32'h0000_0800, 1'b1);
        check("tp_b_instr", last_instr, 32'hFE00_0EE3);
        check("tp_b_addr", last_addr, 2);
        cycle(1'b1, 2'd0, 32'h0000_0093, 32'd2048, 1'b1);
        check("tp_j_instr", last_instr, 32'h0010_00EF);
        check("tp_j_addr", last_addr, 3);
        cycle(1'b1, 2'd2, 32'h0000_0063, 32'd3, 1'b1);
`ifdef IMM_ENC_SAT_EN
        check("tp_irange_instr", last_instr, 32'h7FF0_0093);
`else
        check("tp_irange_instr", last_instr, 32'h8000_0093);
`endif
        check("tp_irange_err", last_err, 1);
        check("tp_irange_sticky", err_sticky, 1);
        check("tp_irange_eaddr", err_addr, 4);
        check("tp_irange_cnt", err_cnt, 1);
        cycle(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
        check("tp_bmis_instr", last_instr, 32'h0000_0163);
        check("tp_bmis_err", last_err, 1);
        check("tp_bmis_eaddr", err_addr, 4);
        check("tp_bmis_cnt", err_cnt, 2);

        cycle(1'b1, 2'd0, 32'h0000_0093, 32'd5, 1'b1);
        for (int k = 0; k < 5; k++) cycle(1'b1, 2'd3, 32'h0000_00EF, $urandom, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        out_count = 0; m_cnt = 0; m_sticky = 1'b0; m_eaddr = 0;
        reset_checks("rst_hold");

        for (int k = 0; k < 8000 && out_count < 1100; k++) begin
            rf = 2'($urandom_range(0, 3));
            cycle($urandom_range(0, 3) != 0, rf, $urandom, rand_imm(rf), $urandom_range(0, 3) != 0);
        end
        if (out_count < 1100) check("stream_budget", out_count, 1100);
        for (int k = 0; k < 10 && q.size() != 0; k++) cycle(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
        cycle(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
        check("final_addr", out_addr, out_count % 1024);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
